simd_unpack_pipe: RTL and testbench

//  Pipelined, parametrised SIMD interleave/narrow unit for the ALU datapath. Implements UNPCKLO,

---
 rtl/simd_unpack_pipe_pkg.sv | 26 ++
 rtl/simd_unpack_pipe_lane_shuffle.sv | 83 ++++++++
 rtl/simd_unpack_pipe.sv | 113 +++++++++++
 tb/tb_simd_unpack_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_unpack_pipe_pkg.sv
// Shared encodings and helpers for the SIMD interleave/narrow unit.
package simd_unpack_pipe_pkg;

  localparam int SIMD_WIDTH_DEFAULT = 256;

  // Element-width encodings on in_mode. Anything above MODE_128 is full-width.
  localparam logic [2:0] MODE_8    = 3'd0;
  localparam logic [2:0] MODE_16   = 3'd1;
  localparam logic [2:0] MODE_32   = 3'd2;
  localparam logic [2:0] MODE_64   = 3'd3;
  localparam logic [2:0] MODE_128  = 3'd4;
  localparam logic [2:0] MODE_FULL = 3'd5;

  // Operation encodings on in_op.
  localparam logic [1:0] OP_UNPCKLO = 2'd0;
  localparam logic [1:0] OP_UNPCKHI = 2'd1;
  localparam logic [1:0] OP_PACK    = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  // True when the op/mode pair has no defined transform and A is forwarded
  // unchanged. PACK from 256-bit sources to 128-bit lanes is not defined.
  function automatic logic is_passthrough(input logic [2:0] mode, input logic [1:0] op);
    return (op == OP_RSVD) || (mode >= MODE_FULL) || ((op == OP_PACK) && (mode == MODE_128));
  endfunction

endpackage

// File: rtl/simd_unpack_pipe_lane_shuffle.sv
// Combinational lane network: interleave (UNPCKLO/HI) and signed-saturating
// narrow (PACK) of two SW-bit operands. Every width is built in parallel and
// the mode/op pair selects one result.
module simd_lane_shuffle
  import simd_unpack_pipe_pkg::*;
#(
  parameter int SW = SIMD_WIDTH_DEFAULT
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic [2:0]    mode,
  input  logic [1:0]    op,
  output logic [SW-1:0] data,
  output logic          sat
);

  localparam int H = SW / 2;

  logic [SW-1:0] unp_lo  [5];
  logic [SW-1:0] unp_hi  [5];
  logic [SW-1:0] pk_data [4];
  logic [3:0]    pk_sat;

  // Interleave networks for element widths 8..128: lane pair i = {A_i, B_i}.
  for (genvar k = 0; k < 5; k++) begin : g_unp
    localparam int W = 8 << k;
    logic [SW-1:0] lo;
    logic [SW-1:0] hi;
    for (genvar i = 0; i < H / W; i++) begin : g_lane
      assign lo[2*i*W +: W]     = b[i*W +: W];
      assign lo[(2*i+1)*W +: W] = a[i*W +: W];
      assign hi[2*i*W +: W]     = b[H + i*W +: W];
      assign hi[(2*i+1)*W +: W] = a[H + i*W +: W];
    end
    assign unp_lo[k] = lo;
    assign unp_hi[k] = hi;
  end

  // Narrowing networks for destination widths 8..64. B fills the low half,
  // A the high half. A source fits when its top W+1 bits are all equal.
  for (genvar k = 0; k < 4; k++) begin : g_pack
    localparam int W = 8 << k;
    localparam int N = H / W;
    logic [SW-1:0]  pd;
    logic [2*N-1:0] lane_sat;
    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [2*W-1:0] src_b;
      logic [2*W-1:0] src_a;
      logic           ovf_b;
      logic           ovf_a;
      assign src_b = b[i*2*W +: 2*W];
      assign src_a = a[i*2*W +: 2*W];
      assign ovf_b = !((&src_b[2*W-1:W-1]) || !(|src_b[2*W-1:W-1]));
      assign ovf_a = !((&src_a[2*W-1:W-1]) || !(|src_a[2*W-1:W-1]));
      assign pd[i*W +: W] = !ovf_b ? src_b[W-1:0] :
                            (src_b[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
      assign pd[H + i*W +: W] = !ovf_a ? src_a[W-1:0] :
                                (src_a[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
      assign lane_sat[i]     = ovf_b;
      assign lane_sat[N + i] = ovf_a;
    end
    assign pk_data[k] = pd;
    assign pk_sat[k]  = |lane_sat;
  end

  // Result select; anything without a defined transform forwards A with no saturation.
  always_comb begin
    data = a;
    sat  = 1'b0;
    if (!is_passthrough(mode, op)) begin
      case (op)
        OP_UNPCKLO: data = unp_lo[mode];
        OP_UNPCKHI: data = unp_hi[mode];
        OP_PACK: begin
          data = pk_data[mode[1:0]];
          sat  = pk_sat[mode[1:0]];
        end
        default: data = a;
      endcase
    end
  end

endmodule

// File: rtl/simd_unpack_pipe.sv
// Two-stage pipeline around the SIMD lane shuffle. S1 holds operands, S2
// holds the computed result. Fixed 2-cycle latency, one op per clock.
//
// Handshake: a transfer happens on a rising edge where valid && ready on that
// side. in_ready depends only on internal valid flags and out_ready, never on
// in_valid. out_data/out_sat are held stable while out_valid && !out_ready.
module simd_unpack_pipe
  import simd_unpack_pipe_pkg::*;
#(
  parameter int SIMD_WIDTH = SIMD_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIMD_WIDTH-1:0] in_a,
  input  logic [SIMD_WIDTH-1:0] in_b,
  input  logic [2:0]            in_mode,
  input  logic [1:0]            in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIMD_WIDTH-1:0] out_data,
  output logic                  out_sat
);

  logic                  s1_valid_q, s1_valid_d;
  logic [SIMD_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [SIMD_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]            s1_mode_q, s1_mode_d;
  logic [1:0]            s1_op_q, s1_op_d;
  logic                  out_valid_q, out_valid_d;
  logic [SIMD_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_sat_q, out_sat_d;

  logic                  s2_en;
  logic                  s1_en;
  logic [SIMD_WIDTH-1:0] shuf_data;
  logic                  shuf_sat;

  simd_lane_shuffle #(
    .SW(SIMD_WIDTH)
  ) u_shuffle (
    .a    (s1_a_q),
    .b    (s1_b_q),
    .mode (s1_mode_q),
    .op   (s1_op_q),
    .data (shuf_data),
    .sat  (shuf_sat)
  );

  // Stage enables: a stage advances when it is empty or its successor advances.
  always_comb begin
    s2_en    = !out_valid_q || out_ready;
    s1_en    = !s1_valid_q || s2_en;
    in_ready = s1_en;
  end

  // Next-state for both stages; frozen stages hold their contents.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mode_d   = s1_mode_q;
    s1_op_d     = s1_op_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d    = in_a;
        s1_b_d    = in_b;
        s1_mode_d = in_mode;
        s1_op_d   = in_op;
      end
    end
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = shuf_data;
        out_sat_d  = shuf_sat;
      end
    end
  end

  // Pipeline registers; reset discards every in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= MODE_8;
      s1_op_q     <= OP_UNPCKLO;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_simd_unpack_pipe.sv
// Directed bench for simd_unpack_pipe: reset, interleave, pack, throughput
// and stall behaviour, checked through an in-order expected queue.
module tb_simd_unpack_pipe;

  localparam int SW = 256;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_a;
  logic [SW-1:0] in_b;
  logic [2:0]    in_mode;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_data;
  logic          out_sat;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  simd_unpack_pipe #(.SIMD_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  // ---------------- scoreboard ----------------
  logic [SW-1:0] exp_q[$];
  logic          exp_sat_q[$];
  int            pop_cyc[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check_eq(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic [SW-1:0] d, input logic s);
    exp_q.push_back(d);
    exp_sat_q.push_back(s);
  endtask

  // Output monitor: a beat seen valid&&ready at the negedge transfers on the next posedge.
  always @(negedge clk) begin
    logic [SW-1:0] e;
    logic          es;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", SW'(exp_q.size()), SW'(1));
      end else begin
        e  = exp_q.pop_front();
        es = exp_sat_q.pop_front();
        check_eq("out_data", out_data, e);
        check_eq("out_sat", SW'(out_sat), SW'(es));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send(input logic [SW-1:0] a, input logic [SW-1:0] b,
                      input logic [2:0] mode, input logic [1:0] op);
    int t;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_op    = op;
    in_valid = 1'b1;
    t = 0;
    while (t <= 50) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (t > 50) check_eq("send_timeout", SW'(t), SW'(0));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    check_eq("drain", SW'(exp_q.size()), SW'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [SW-1:0] a, b, e;
    logic [SW-1:0] p0, p1, p2;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_mode = '0; in_op = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", SW'(out_valid), SW'(0));
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_out_sat", SW'(out_sat), SW'(0));
    check_eq("rst_in_ready", SW'(in_ready), SW'(1));
    @(posedge clk); #1; rst = 1'b0;

    // 1. Reset with two ops in flight
    out_ready = 1'b0;
    send({SW{1'b1}}, '0, 3'd7, 2'd0);
    send(SW'(256'h1234), '0, 3'd1, 2'd3);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_valid", SW'(out_valid), SW'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check_eq("midrst_out_valid", SW'(out_valid), SW'(0));
    check_eq("midrst_out_data", out_data, '0);
    check_eq("midrst_in_ready", SW'(in_ready), SW'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("post_rst_quiet", SW'(out_valid), SW'(0));
      check_eq("post_rst_in_ready", SW'(in_ready), SW'(1));
    end
    @(posedge clk); #1;

    // 2. UNPCKLO bytes, latency
    for (int k = 0; k < 32; k++) begin
      a[8*k +: 8] = 8'(k);
      b[8*k +: 8] = 8'(8'h80 + k);
    end
    e = '0;
    for (int k = 0; k < 16; k++) e[16*k +: 16] = {8'(k), 8'(8'h80 + k)};
    expect_out(e, 1'b0);
    send(a, b, 3'd0, 2'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_edge_n", SW'(out_valid), SW'(0));
    @(negedge clk);
    check_eq("lat_edge_n1", SW'(out_valid), SW'(1));
    check_eq("unpcklo_hw0", SW'(out_data[15:0]), SW'(16'h0080));
    check_eq("unpcklo_hw1", SW'(out_data[31:16]), SW'(16'h0181));
    wait_drain();

    // 3. UNPCKHI 32-bit words
    for (int k = 0; k < 8; k++) a[32*k +: 32] = 32'h1000_0000 + 32'(k);
    for (int k = 0; k < 4; k++) e[64*k +: 64] = {a[32*(4+k) +: 32], a[32*(4+k) +: 32]};
    expect_out(e, 1'b0);
    send(a, a, 3'd2, 2'd1);
    in_valid = 1'b0;
    wait_drain();

    // 4. PACK: byte saturation, halfword in range, 64-bit saturation, mode4 passthrough
    a = '0; b = '0;
    b[63:0] = 64'hFFFF_007F_FF00_0100;
    e = '0; e[31:0] = 32'hFF7F_807F;
    expect_out(e, 1'b1);
    send(a, b, 3'd0, 2'd2);
    a = '0; b = '0;
    a[63:0] = 64'hFFFF_8000_0000_7FFF;
    e = '0; e[159:128] = 32'h8000_7FFF;
    expect_out(e, 1'b0);
    send(a, b, 3'd1, 2'd2);
    a = '0; b = '0;
    b[127:0]   = 128'hFFFF_FFFF_0000_0000_0000_0000_0000_0000;
    b[255:128] = 128'h0000_0000_0000_0000_1234_5678_9ABC_DEF0;
    e = '0; e[63:0] = 64'h8000_0000_0000_0000; e[127:64] = 64'h1234_5678_9ABC_DEF0;
    expect_out(e, 1'b1);
    send(a, b, 3'd3, 2'd2);
    a = {8{32'hDEAD_BEEF}};
    b = {8{32'h7FFF_FFFF}};
    expect_out(a, 1'b0);
    send(a, b, 3'd4, 2'd2);
    in_valid = 1'b0;
    wait_drain();

    // 5. Eight back-to-back ops, then a stall
    pop_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      a = {8{32'(k * 32'h0101_0101 + 32'h10)}};
      b = {8{32'($urandom)}};
      if (k % 2 == 0) begin
        expect_out(a, 1'b0);
        send(a, b, 3'($urandom_range(0, 7)), 2'd3);
      end else begin
        expect_out({a[127:0], b[127:0]}, 1'b0);
        send(a, b, 3'd4, 2'd0);
      end
    end
    in_valid = 1'b0;
    wait_drain();
    check_eq("b2b_count", SW'(pop_cyc.size()), SW'(8));
    if (pop_cyc.size() == 8)
      for (int k = 0; k < 7; k++)
        check_eq("b2b_gap", SW'(pop_cyc[k+1] - pop_cyc[k]), SW'(1));

    p0 = {4{64'hAAAA_0000_0000_0001}};
    p1 = {4{64'hBBBB_0000_0000_0002}};
    p2 = {4{64'hCCCC_0000_0000_0003}};
    out_ready = 1'b0;
    expect_out(p0, 1'b0);
    expect_out(p1, 1'b0);
    expect_out(p2, 1'b0);
    send(p0, '0, 3'd0, 2'd3);
    send(p1, '0, 3'd0, 2'd3);
    in_a = p2; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("stall_in_ready", SW'(in_ready), SW'(0));
      check_eq("stall_out_valid", SW'(out_valid), SW'(1));
      check_eq("stall_out_data", out_data, p0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(p2, '0, 3'd0, 2'd3);
    in_valid = 1'b0;
    wait_drain();

    // 6. Illegal mode / reserved op forward A
    a = {16{16'h5A3C}};
    b = {16{16'hFFFF}};
    expect_out(a, 1'b0);
    send(a, b, 3'd7, 2'd0);
    a = {16{16'hC3A5}};
    expect_out(a, 1'b0);
    send(a, b, 3'd1, 2'd3);
    in_valid = 1'b0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
